// File: rtl/conv_pkg.sv
// Shared types and constants for the multiplier pool: lane states, default
// job length and the accumulator-width sizing rule.
package conv_pkg;

  typedef enum logic [1:0] {
    LANE_FREE,
    LANE_LOADED,
    LANE_RUN,
    LANE_DONE
  } lane_state_t;

  localparam int F_DEF = 3;
  localparam int K_DEF = 3;
  localparam int E     = F_DEF * F_DEF * K_DEF;

  // Narrowest accumulator that can hold E full-scale signed products.
  function automatic int acc_w_min(input int w, input int e);
    return 2 * w + $clog2(e);
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One serial MAC lane: latches a window/filter job, accumulates one element
// product per enabled cycle, then holds its result until drained.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int W     = 24,
  parameter int NE    = 27,
  parameter int IDXW  = 24,
  parameter int ACC_W = 53
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [NE*W-1:0]   load_img,
  input  logic [NE*W-1:0]   load_flt,
  input  logic [IDXW-1:0]   load_idx,
  input  logic              load_last,
  input  logic              mult_en,
  input  logic              drain,
  output logic              busy,
  output logic              done,
  output logic [IDXW-1:0]   idx,
  output logic              last,
  output logic [ACC_W-1:0]  acc
);

  localparam int CW = (NE > 1) ? $clog2(NE) : 1;

  lane_state_t            state;
  logic [NE*W-1:0]        img;
  logic [NE*W-1:0]        flt;
  logic [CW-1:0]          cnt;
  logic signed [W-1:0]    a;
  logic signed [W-1:0]    b;
  logic signed [2*W-1:0]  prod;

  assign a    = img[cnt*W +: W];
  assign b    = flt[cnt*W +: W];
  assign prod = a * b;
  assign busy = (state != LANE_FREE);
  assign done = (state == LANE_DONE);

  // Lane lifecycle; the accumulator only moves on enabled cycles before DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= LANE_FREE;
      img   <= '0;
      flt   <= '0;
      idx   <= '0;
      last  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        LANE_FREE: begin
          if (load) begin
            img   <= load_img;
            flt   <= load_flt;
            idx   <= load_idx;
            last  <= load_last;
            cnt   <= '0;
            acc   <= '0;
            state <= LANE_LOADED;
          end
        end
        LANE_LOADED, LANE_RUN: begin
          if (mult_en) begin
            acc <= acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
            if (cnt == CW'(NE - 1)) begin
              state <= LANE_DONE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= LANE_RUN;
            end
          end
        end
        LANE_DONE: begin
          if (drain) state <= LANE_FREE;
        end
        default: state <= LANE_FREE;
      endcase
    end
  end

endmodule

// File: rtl/conv_mult_pool.sv
// Pool of NMULT serial MAC lanes: job accept decode, lowest-lane-first result
// presentation and batch completion tracking for the convolution controller.
module conv_mult_pool
  import conv_pkg::*;
#(
  parameter int NMULT = 4,
  parameter int MMULT = 2,
  parameter int W     = 24,
  parameter int F     = 3,
  parameter int K     = 3,
  parameter int IDXW  = 24,
  parameter int ACC_W = 53
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 mult_en,
  input  logic                 load_valid,
  input  logic [MMULT-1:0]     load_lane,
  input  logic [IDXW-1:0]      load_idx,
  input  logic                 load_last,
  input  logic [F*F*K*W-1:0]   load_img,
  input  logic [F*F*K*W-1:0]   load_flt,
  output logic                 load_err,
  output logic [NMULT-1:0]     mult_busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [MMULT-1:0]     res_lane,
  output logic [IDXW-1:0]      res_idx,
  output logic [ACC_W-1:0]     res_data,
  output logic                 conv_done_partial,
  output logic                 conv_done_full
);

  localparam int NE = F * F * K;
  localparam int OW = $clog2(NMULT + 1);

  if (ACC_W < acc_w_min(W, NE)) begin : g_acc_w_check
    $error("ACC_W is too narrow for W and F*F*K");
  end

  logic [NMULT-1:0] lane_load, lane_drain, lane_done, lane_last;
  logic [IDXW-1:0]  lane_idx [NMULT];
  logic [ACC_W-1:0] lane_acc [NMULT];
  logic             accept, drain, res_last;
  logic             pick_valid;
  logic [MMULT-1:0] pick_lane;
  logic [OW-1:0]    outstanding, out_next;
  logic             batch_active, last_seen, ba_next, ls_next;

  // A lane being drained this edge still reads busy, so a load aimed at it is refused.
  assign accept = load_valid && !mult_busy[load_lane];
  assign drain  = res_valid && res_ready;

  for (genvar l = 0; l < NMULT; l++) begin : g_lane
    assign lane_load[l]  = accept && (load_lane == MMULT'(l));
    assign lane_drain[l] = drain && (res_lane == MMULT'(l));

    conv_mac_lane #(.W(W), .NE(NE), .IDXW(IDXW), .ACC_W(ACC_W)) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .load      (lane_load[l]),
      .load_img  (load_img),
      .load_flt  (load_flt),
      .load_idx  (load_idx),
      .load_last (load_last),
      .mult_en   (mult_en),
      .drain     (lane_drain[l]),
      .busy      (mult_busy[l]),
      .done      (lane_done[l]),
      .idx       (lane_idx[l]),
      .last      (lane_last[l]),
      .acc       (lane_acc[l])
    );
  end

  // Lowest finished lane that is not leaving this very edge.
  always_comb begin
    pick_valid = 1'b0;
    pick_lane  = '0;
    for (int l = NMULT - 1; l >= 0; l--) begin
      if (lane_done[l] && !lane_drain[l]) begin
        pick_valid = 1'b1;
        pick_lane  = MMULT'(l);
      end
    end
  end

  // The presented result is frozen until the consumer takes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_valid <= 1'b0;
      res_lane  <= '0;
      res_idx   <= '0;
      res_data  <= '0;
      res_last  <= 1'b0;
    end else if (!res_valid || res_ready) begin
      res_valid <= pick_valid;
      res_lane  <= pick_lane;
      res_idx   <= pick_valid ? lane_idx[pick_lane]  : '0;
      res_data  <= pick_valid ? lane_acc[pick_lane]  : '0;
      res_last  <= pick_valid ? lane_last[pick_lane] : 1'b0;
    end
  end

  always_comb begin
    out_next = outstanding + OW'(accept) - OW'(drain);
    ba_next  = accept | (batch_active & ~clr);
    ls_next  = ~clr & (last_seen | (drain & res_last));
  end

  // Done flags are registered from the post-edge tracking values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding       <= '0;
      batch_active      <= 1'b0;
      last_seen         <= 1'b0;
      conv_done_partial <= 1'b0;
      conv_done_full    <= 1'b0;
      load_err          <= 1'b0;
    end else begin
      outstanding       <= out_next;
      batch_active      <= ba_next;
      last_seen         <= ls_next;
      conv_done_partial <= (out_next == '0) && ba_next;
      conv_done_full    <= (out_next == '0) && ba_next && ls_next;
      load_err          <= load_valid && mult_busy[load_lane];
    end
  end

endmodule

// File: tb/tb_conv_mult_pool.sv
// Self-checking bench for conv_mult_pool: constant-result job table, directed
// corner sequences, and a randomized run against a job-level reference model.
module tb_conv_mult_pool;

  localparam int NMULT = 4;
  localparam int MMULT = 2;
  localparam int W     = 24;
  localparam int F     = 3;
  localparam int K     = 3;
  localparam int IDXW  = 24;
  localparam int ACC_W = 53;
  localparam int NE    = F * F * K;
  localparam int EW    = NE * W;

  logic             clk = 1'b0;
  logic             rstn, clr, mult_en, load_valid, load_last, res_ready;
  logic [MMULT-1:0] load_lane;
  logic [IDXW-1:0]  load_idx;
  logic [EW-1:0]    load_img, load_flt;
  logic             load_err, res_valid, conv_done_partial, conv_done_full;
  logic [NMULT-1:0] mult_busy;
  logic [MMULT-1:0] res_lane;
  logic [IDXW-1:0]  res_idx;
  logic [ACC_W-1:0] res_data;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  conv_mult_pool #(
    .NMULT(NMULT), .MMULT(MMULT), .W(W), .F(F), .K(K), .IDXW(IDXW), .ACC_W(ACC_W)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .clr               (clr),
    .mult_en           (mult_en),
    .load_valid        (load_valid),
    .load_lane         (load_lane),
    .load_idx          (load_idx),
    .load_last         (load_last),
    .load_img          (load_img),
    .load_flt          (load_flt),
    .load_err          (load_err),
    .mult_busy         (mult_busy),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_lane          (res_lane),
    .res_idx           (res_idx),
    .res_data          (res_data),
    .conv_done_partial (conv_done_partial),
    .conv_done_full    (conv_done_full)
  );

  typedef struct {
    int     ib, is, fb, fs;
    int     idx;
    bit     last;
    longint exp;
  } vec_t;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Element e = base + e*stride, truncated to W bits.
  function automatic logic [EW-1:0] make_vec(input int base, input int stride);
    logic [EW-1:0] v;
    for (int e = 0; e < NE; e++) v[e*W +: W] = W'(base + e * stride);
    return v;
  endfunction

  function automatic logic [EW-1:0] rand_vec();
    logic [EW-1:0] v;
    for (int e = 0; e < NE; e++) v[e*W +: W] = W'($urandom);
    return v;
  endfunction

  // Reference dot product in plain 64-bit signed arithmetic.
  function automatic longint dot(input logic [EW-1:0] x, input logic [EW-1:0] y);
    longint s;
    logic signed [W-1:0] a, b;
    s = 0;
    for (int e = 0; e < NE; e++) begin
      a = x[e*W +: W];
      b = y[e*W +: W];
      s += longint'(a) * longint'(b);
    end
    return s;
  endfunction

  function automatic logic [63:0] acc64(input longint v);
    logic [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return {{(64-ACC_W){1'b0}}, t};
  endfunction

  task automatic apply_stimulus(input logic [MMULT-1:0] lane, input logic [EW-1:0] img,
                                input logic [EW-1:0] flt, input logic [IDXW-1:0] idx,
                                input logic last);
    load_valid = 1'b1;
    load_lane  = lane;
    load_img   = img;
    load_flt   = flt;
    load_idx   = idx;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic wait_result(input int max_cyc, output int lat);
    lat = 0;
    while (!res_valid && lat < max_cyc) begin
      step();
      lat++;
    end
    if (!res_valid) begin
      n_total++;
      $display("[TB] FAIL wait_result: res_valid not seen within %0d cycles", max_cyc);
    end
  endtask

  vec_t             tbl[7];
  int               lat, lat2;
  bit               mbusy[NMULT];
  int               mrem[NMULT];
  logic [IDXW-1:0]  midx[NMULT];
  longint           mexp[NMULT];
  logic [NMULT-1:0] mb;
  logic [EW-1:0]    rimg, rflt;
  logic [MMULT-1:0] rl, dl;
  bit               do_drain, do_acc, exp_err, en_now;

  initial begin
    tbl[0] = '{1, 0, 2, 0, 5, 1'b1, 64'sd54};
    tbl[1] = '{-1, 0, 8388607, 0, 9, 1'b0, -64'sd226492389};
    tbl[2] = '{3, 0, -4, 0, 11, 1'b1, -64'sd324};
    tbl[3] = '{8388607, 0, -8388608, 0, 12, 1'b0, -64'sd1899955866304512};
    tbl[4] = '{1, 1, 1, 0, 13, 1'b0, 64'sd378};
    tbl[5] = '{0, 1, 0, 1, 14, 1'b1, 64'sd6201};
    tbl[6] = '{-8388608, 0, -8388608, 0, 15, 1'b0, 64'sd1899956092796928};

    rstn = 1'b1; clr = 1'b0; mult_en = 1'b1; load_valid = 1'b0; load_last = 1'b0;
    res_ready = 1'b1; load_lane = '0; load_idx = '0; load_img = '0; load_flt = '0;
    #2 rstn = 1'b0;
    repeat (3) step();
    check_output("reset_busy", 64'(mult_busy), 64'd0);
    check_output("reset_valid", 64'(res_valid), 64'd0);
    check_output("reset_data", 64'(res_data), 64'd0);
    check_output("reset_idx", 64'(res_idx), 64'd0);
    check_output("reset_err", 64'(load_err), 64'd0);
    check_output("reset_partial", 64'(conv_done_partial), 64'd0);
    check_output("reset_full", 64'(conv_done_full), 64'd0);
    rstn = 1'b1;
    step();

    // Table of single jobs on lane 0 with hand-computed results.
    for (int i = 0; i < 7; i++) begin
      pulse_clr();
      apply_stimulus(2'd0, make_vec(tbl[i].ib, tbl[i].is), make_vec(tbl[i].fb, tbl[i].fs),
                     IDXW'(tbl[i].idx), tbl[i].last);
      check_output("tbl_busy_rise", 64'(mult_busy), 64'b0001);
      wait_result(40, lat);
      check_output("tbl_latency", 64'(lat), 64'd28);
      check_output("tbl_data", 64'(res_data), acc64(tbl[i].exp));
      check_output("tbl_idx", 64'(res_idx), 64'(tbl[i].idx));
      check_output("tbl_lane", 64'(res_lane), 64'd0);
      step();
      check_output("tbl_valid_drop", 64'(res_valid), 64'd0);
      check_output("tbl_busy_fall", 64'(mult_busy), 64'd0);
      check_output("tbl_partial", 64'(conv_done_partial), 64'd1);
      check_output("tbl_full", 64'(conv_done_full), 64'(tbl[i].last));
    end

    // mult_en low for 5 cycles mid-run stretches latency by 5.
    pulse_clr();
    apply_stimulus(2'd0, make_vec(1, 0), make_vec(2, 0), 24'd5, 1'b1);
    repeat (10) step();
    mult_en = 1'b0;
    repeat (5) step();
    mult_en = 1'b1;
    wait_result(50, lat2);
    check_output("stall_latency", 64'(15 + lat2), 64'd33);
    check_output("stall_data", 64'(res_data), acc64(54));
    step();
    check_output("stall_full", 64'(conv_done_full), 64'd1);

    // Load into a running lane is dropped and leaves the job intact.
    apply_stimulus(2'd1, make_vec(2, 1), make_vec(-3, 0), 24'd7, 1'b0);
    repeat (5) step();
    apply_stimulus(2'd1, make_vec(1, 0), make_vec(2, 0), 24'd8, 1'b0);
    check_output("busy_err_pulse", 64'(load_err), 64'd1);
    check_output("busy_err_map", 64'(mult_busy), 64'b0010);
    step();
    check_output("busy_err_clear", 64'(load_err), 64'd0);
    wait_result(40, lat);
    check_output("busy_err_idx", 64'(res_idx), 64'd7);
    check_output("busy_err_data", 64'(res_data), acc64(-1215));
    check_output("busy_err_lane", 64'(res_lane), 64'd1);
    step();

    // Lanes 0 and 2 finish together; consumer stalls 3 cycles.
    pulse_clr();
    res_ready = 1'b0;
    mult_en = 1'b0;
    apply_stimulus(2'd0, make_vec(1, 0), make_vec(2, 0), 24'd20, 1'b0);
    apply_stimulus(2'd2, make_vec(3, 0), make_vec(-4, 0), 24'd22, 1'b0);
    mult_en = 1'b1;
    wait_result(40, lat);
    check_output("pair_first_lane", 64'(res_lane), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("pair_hold_valid", 64'(res_valid), 64'd1);
      check_output("pair_hold_lane", 64'(res_lane), 64'd0);
      check_output("pair_hold_idx", 64'(res_idx), 64'd20);
      check_output("pair_hold_data", 64'(res_data), acc64(54));
    end
    check_output("pair_busy", 64'(mult_busy), 64'b0101);
    res_ready = 1'b1;
    load_valid = 1'b1;
    load_lane = 2'd0;
    step();
    load_valid = 1'b0;
    check_output("freed_lane_reject", 64'(load_err), 64'd1);
    check_output("pair_second_lane", 64'(res_lane), 64'd2);
    check_output("pair_second_idx", 64'(res_idx), 64'd22);
    check_output("pair_second_data", 64'(res_data), acc64(-324));
    check_output("pair_busy_after0", 64'(mult_busy), 64'b0100);
    check_output("pair_partial_early", 64'(conv_done_partial), 64'd0);
    step();
    check_output("pair_valid_drop", 64'(res_valid), 64'd0);
    check_output("pair_busy_empty", 64'(mult_busy), 64'd0);
    check_output("pair_partial", 64'(conv_done_partial), 64'd1);
    check_output("pair_full", 64'(conv_done_full), 64'd0);

    // Async reset with a held result and three running lanes.
    res_ready = 1'b0;
    apply_stimulus(2'd3, make_vec(1, 0), make_vec(1, 0), 24'd30, 1'b1);
    wait_result(40, lat);
    apply_stimulus(2'd0, make_vec(1, 0), make_vec(1, 0), 24'd31, 1'b0);
    apply_stimulus(2'd1, make_vec(1, 0), make_vec(1, 0), 24'd32, 1'b0);
    apply_stimulus(2'd2, make_vec(1, 0), make_vec(1, 0), 24'd33, 1'b0);
    repeat (3) step();
    #2 rstn = 1'b0;
    #1;
    check_output("rst_mid_busy", 64'(mult_busy), 64'd0);
    check_output("rst_mid_valid", 64'(res_valid), 64'd0);
    check_output("rst_mid_partial", 64'(conv_done_partial), 64'd0);
    check_output("rst_mid_full", 64'(conv_done_full), 64'd0);
    #1 rstn = 1'b1;
    step();
    res_ready = 1'b1;
    apply_stimulus(2'd2, make_vec(-1, 0), make_vec(8388607, 0), 24'd40, 1'b0);
    wait_result(40, lat);
    check_output("rst_after_latency", 64'(lat), 64'd28);
    check_output("rst_after_data", 64'(res_data), acc64(-226492389));
    check_output("rst_after_lane", 64'(res_lane), 64'd2);
    step();

    // Randomized traffic against a job-level model.
    for (int l = 0; l < NMULT; l++) begin
      mbusy[l] = 1'b0; mrem[l] = 0; midx[l] = '0; mexp[l] = 0;
    end
    for (int cyc = 0; cyc < 700; cyc++) begin
      en_now     = (cyc >= 500) || ($urandom_range(0, 3) != 0);
      mult_en    = en_now;
      res_ready  = (cyc >= 500) || ($urandom_range(0, 2) != 0);
      load_valid = (cyc < 500) && ($urandom_range(0, 3) == 0);
      rl         = MMULT'($urandom_range(0, NMULT - 1));
      rimg       = rand_vec();
      rflt       = rand_vec();
      load_lane  = rl;
      load_img   = rimg;
      load_flt   = rflt;
      load_idx   = IDXW'($urandom);
      do_drain   = res_valid && res_ready;
      dl         = res_lane;
      if (do_drain) begin
        check_output("rnd_lane_finished", {62'd0, mbusy[dl], mrem[dl] == 0}, 64'b11);
        check_output("rnd_idx", 64'(res_idx), 64'(midx[dl]));
        check_output("rnd_data", 64'(res_data), acc64(mexp[dl]));
      end
      do_acc  = load_valid && !mbusy[rl];
      exp_err = load_valid && mbusy[rl];
      step();
      for (int l = 0; l < NMULT; l++)
        if (en_now && mbusy[l] && mrem[l] > 0) mrem[l]--;
      if (do_drain) mbusy[dl] = 1'b0;
      if (do_acc) begin
        mbusy[rl] = 1'b1;
        mrem[rl]  = NE;
        midx[rl]  = load_idx;
        mexp[rl]  = dot(rimg, rflt);
      end
      for (int l = 0; l < NMULT; l++) mb[l] = mbusy[l];
      check_output("rnd_err", 64'(load_err), 64'(exp_err));
      check_output("rnd_busy", 64'(mult_busy), 64'(mb));
    end
    load_valid = 1'b0;
    check_output("rnd_end_busy", 64'(mult_busy), 64'd0);
    check_output("rnd_end_partial", 64'(conv_done_partial), 64'd1);
    check_output("rnd_end_full", 64'(conv_done_full), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
